pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_seq_pkg.sv | 23 ++
 rtl/pc_next_sel.sv | 59 +++++
 rtl/pc_sequencer.sv | 167 ++++++++++++++++
 tb/tb_pc_sequencer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// -----------------------------------------------------------------------------
// pc_seq_pkg
// Shared definitions for the PC sequencer: default PC width and vectors, the
// instruction size used for sequential increments, and the sequencer state
// encoding. Imported by pc_next_sel and pc_sequencer.
// -----------------------------------------------------------------------------
package pc_seq_pkg;

    localparam int          WIDTH_PC_DEF     = 32;
    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR_DEF   = 32'h0000_0180;

    // Every instruction is one 32-bit word.
    localparam int          INSTR_BYTES      = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,  // one-cycle hold after reset
        ST_FETCH = 2'd1,  // request outstanding at pc_q
        ST_VALID = 2'd2,  // instruction presented to decode
        ST_FLUSH = 2'd3   // drain a request that was abandoned by a trap
    } seq_state_e;

endpackage : pc_seq_pkg

// File: rtl/pc_next_sel.sv
// -----------------------------------------------------------------------------
// pc_next_sel
// Purely combinational next-PC selection for the sequencer.
// Priority: exception > eret > jump > taken branch > sequential (pc + 4).
// All redirect targets are word-aligned by clearing bits [1:0]; the sequential
// increment wraps modulo 2^WIDTH_PC.
//
// Ports
//   i_exception      trap request            -> EXC_VECTOR
//   i_eret           return from exception   -> i_epc
//   i_jump           unconditional redirect  -> i_jump_target
//   i_branch_taken   conditional redirect    -> i_branch_target
//   i_epc            saved exception return address
//   i_jump_target    jump destination
//   i_branch_target  branch destination
//   i_pc             address of the instruction being retired
//   o_next_pc        selected next fetch address
//   o_pc_plus4       i_pc + 4 (wrapping)
// -----------------------------------------------------------------------------
module pc_next_sel
    import pc_seq_pkg::*;
#(
    parameter int                  WIDTH_PC   = WIDTH_PC_DEF,
    parameter logic [WIDTH_PC-1:0] EXC_VECTOR = WIDTH_PC'(EXC_VECTOR_DEF)
) (
    input  logic                i_exception,
    input  logic                i_eret,
    input  logic                i_jump,
    input  logic                i_branch_taken,
    input  logic [WIDTH_PC-1:0] i_epc,
    input  logic [WIDTH_PC-1:0] i_jump_target,
    input  logic [WIDTH_PC-1:0] i_branch_target,
    input  logic [WIDTH_PC-1:0] i_pc,
    output logic [WIDTH_PC-1:0] o_next_pc,
    output logic [WIDTH_PC-1:0] o_pc_plus4
);

    function automatic logic [WIDTH_PC-1:0] word_align(input logic [WIDTH_PC-1:0] addr);
        return {addr[WIDTH_PC-1:2], 2'b00};
    endfunction

    // Carry out of the top bit is simply dropped: 0xFFFF_FFFC + 4 = 0.
    assign o_pc_plus4 = i_pc + WIDTH_PC'(INSTR_BYTES);

    always_comb begin
        if (i_exception) begin
            o_next_pc = word_align(EXC_VECTOR);
        end else if (i_eret) begin
            o_next_pc = word_align(i_epc);
        end else if (i_jump) begin
            o_next_pc = word_align(i_jump_target);
        end else if (i_branch_taken) begin
            o_next_pc = word_align(i_branch_target);
        end else begin
            o_next_pc = o_pc_plus4;
        end
    end

endmodule : pc_next_sel

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
// Instruction fetch sequencer. Issues one instruction-memory request at a time,
// holds the returned word for decode until it is consumed, and computes the next
// fetch address from exception / eret / jump / branch / sequential sources.
// A trap taken while a request is outstanding either discards the data in the
// same cycle (ack present) or drains the outstanding request in FLUSH.
//
// Ports
//   i_clk            sole clock, rising edge
//   i_rst            synchronous active-high reset
//   i_stall          decode not ready; held instruction and PC freeze
//   i_branch_taken / i_branch_target   conditional redirect
//   i_jump         / i_jump_target     unconditional redirect
//   i_exception      trap request (honoured in IDLE, FETCH and VALID)
//   i_eret           return from exception to o_epc
//   o_imem_req / o_imem_addr           instruction-memory request
//   i_imem_ack / i_imem_rdata          completion and read data
//   o_instr / o_instr_valid            fetched instruction to decode
//   o_pc / o_pc_plus4                  address of o_instr and that address + 4
//   o_epc            captured exception return address
// -----------------------------------------------------------------------------
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int                  WIDTH_PC     = WIDTH_PC_DEF,
    parameter logic [WIDTH_PC-1:0] RESET_VECTOR = WIDTH_PC'(RESET_VECTOR_DEF),
    parameter logic [WIDTH_PC-1:0] EXC_VECTOR   = WIDTH_PC'(EXC_VECTOR_DEF)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_stall,
    input  logic                i_branch_taken,
    input  logic [WIDTH_PC-1:0] i_branch_target,
    input  logic                i_jump,
    input  logic [WIDTH_PC-1:0] i_jump_target,
    input  logic                i_exception,
    input  logic                i_eret,
    output logic                o_imem_req,
    output logic [WIDTH_PC-1:0] o_imem_addr,
    input  logic                i_imem_ack,
    input  logic [WIDTH_PC-1:0] i_imem_rdata,
    output logic [WIDTH_PC-1:0] o_instr,
    output logic                o_instr_valid,
    output logic [WIDTH_PC-1:0] o_pc,
    output logic [WIDTH_PC-1:0] o_pc_plus4,
    output logic [WIDTH_PC-1:0] o_epc
);

    seq_state_e          state_q, state_d;
    logic [WIDTH_PC-1:0] pc_q,    pc_d;      // next / current fetch address
    logic [WIDTH_PC-1:0] instr_q, instr_d;   // held instruction
    logic [WIDTH_PC-1:0] ipc_q,   ipc_d;     // address of held instruction
    logic [WIDTH_PC-1:0] epc_q,   epc_d;     // exception return address

    logic [WIDTH_PC-1:0] next_pc;

    // Next-PC selection is evaluated against the held instruction's address;
    // it is only used when leaving VALID (consume or trap).
    pc_next_sel #(
        .WIDTH_PC   (WIDTH_PC),
        .EXC_VECTOR (EXC_VECTOR)
    ) u_next_sel (
        .i_exception     (i_exception),
        .i_eret          (i_eret),
        .i_jump          (i_jump),
        .i_branch_taken  (i_branch_taken),
        .i_epc           (epc_q),
        .i_jump_target   (i_jump_target),
        .i_branch_target (i_branch_target),
        .i_pc            (ipc_q),
        .o_next_pc       (next_pc),
        .o_pc_plus4      (o_pc_plus4)
    );

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        epc_d   = epc_q;

        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
                if (i_exception) begin
                    epc_d = pc_q;
                    pc_d  = {EXC_VECTOR[WIDTH_PC-1:2], 2'b00};
                end
            end

            ST_FETCH: begin
                if (i_exception) begin
                    // The request at pc_q never completes architecturally.
                    epc_d = pc_q;
                    pc_d  = {EXC_VECTOR[WIDTH_PC-1:2], 2'b00};
                    // Without an ack the memory still owes us a response,
                    // which must be drained before a new request goes out.
                    state_d = i_imem_ack ? ST_FETCH : ST_FLUSH;
                end else if (i_imem_ack) begin
                    instr_d = i_imem_rdata;
                    ipc_d   = pc_q;
                    state_d = ST_VALID;
                end
            end

            ST_VALID: begin
                // A trap is taken even while decode is stalled; every other
                // redirect waits for the instruction to be consumed.
                if (i_exception || !i_stall) begin
                    pc_d    = next_pc;
                    state_d = ST_FETCH;
                    if (i_exception) begin
                        epc_d = ipc_q;
                    end
                end
            end

            ST_FLUSH: begin
                if (i_imem_ack) begin
                    state_d = ST_FETCH;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        // NOTE: non-blocking assignments so every register samples the values
        // from before this edge, independent of statement order.
        if (i_rst) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_VECTOR;
            instr_q <= '0;
            ipc_q   <= RESET_VECTOR;
            epc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            epc_q   <= epc_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign o_imem_req    = (state_q == ST_FETCH);
    assign o_imem_addr   = pc_q;
    assign o_instr       = instr_q;
    assign o_instr_valid = (state_q == ST_VALID);
    assign o_pc          = ipc_q;
    assign o_epc         = epc_q;

endmodule : pc_sequencer

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
// Self-checking bench for pc_sequencer. A small memory responder acks requests
// with a chosen delay; each completed fetch pushes {address, data} to a
// scoreboard queue, popped and compared when the instruction shows up valid.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

    localparam logic [31:0] EXC_VEC = 32'h0000_0180;
    localparam logic [31:0] RST_VEC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        exception;
    logic        eret;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] epc;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    int        n_checks = 0;
    int        n_errors = 0;

    pc_sequencer dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_stall         (stall),
        .i_branch_taken  (branch_taken),
        .i_branch_target (branch_target),
        .i_jump          (jump),
        .i_jump_target   (jump_target),
        .i_exception     (exception),
        .i_eret          (eret),
        .o_imem_req      (imem_req),
        .o_imem_addr     (imem_addr),
        .i_imem_ack      (imem_ack),
        .i_imem_rdata    (imem_rdata),
        .o_instr         (instr),
        .o_instr_valid   (instr_valid),
        .o_pc            (pc),
        .o_pc_plus4      (pc_plus4),
        .o_epc           (epc)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: act=timeout req=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: act=0x%08h req=0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_redirects();
        branch_taken  = 1'b0;
        branch_target = '0;
        jump          = 1'b0;
        jump_target   = '0;
        exception     = 1'b0;
        eret          = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int budget = 20;
        while (!imem_req && budget > 0) begin
            step();
            budget--;
        end
        if (!imem_req) check({tag, "_req_timeout"}, 32'(imem_req), 32'd1);
    endtask

    // Pop one scoreboard entry and compare it with the presented instruction.
    task automatic check_valid(input string tag);
        sb_entry_t e;
        check({tag, "_valid"}, 32'(instr_valid), 32'd1);
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_pc"},    pc,       e.addr);
            check({tag, "_instr"}, instr,    e.data);
            check({tag, "_plus4"}, pc_plus4, e.addr + 32'd4);
        end
    endtask

    // Expect a request at addr, ack it after `delay` idle cycles, then check
    // the instruction that is presented.
    task automatic fetch(input logic [31:0] addr, input int delay, input string tag);
        wait_req(tag);
        check({tag, "_addr"}, imem_addr, addr);
        check({tag, "_nvalid"}, 32'(instr_valid), 32'd0);
        for (int i = 0; i < delay; i++) begin
            step();
            check({tag, "_hold_req"},  32'(imem_req), 32'd1);
            check({tag, "_hold_addr"}, imem_addr, addr);
        end
        imem_ack   = 1'b1;
        imem_rdata = mem_word(addr);
        sb_q.push_back('{addr: addr, data: mem_word(addr)});
        step();
        imem_ack   = 1'b0;
        imem_rdata = '0;
        check_valid(tag);
    endtask

    // Consume the presented instruction in one cycle with the given redirects.
    task automatic consume(input logic br, input logic [31:0] bt,
                           input logic jp, input logic [31:0] jt,
                           input logic er);
        stall         = 1'b0;
        branch_taken  = br;
        branch_target = bt;
        jump          = jp;
        jump_target   = jt;
        eret          = er;
        step();
        clear_redirects();
    endtask

    initial begin
        rst        = 1'b1;
        stall      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        clear_redirects();
        @(negedge clk);
        step();

        // Reset state.
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_req",   32'(imem_req),    32'd0);
        check("rst_pc",    pc,               RST_VEC);
        check("rst_instr", instr,            32'd0);
        check("rst_epc",   epc,              32'd0);
        check("rst_plus4", pc_plus4,         RST_VEC + 32'd4);

        // Back-to-back fetches with ack in the request cycle.
        rst = 1'b0;
        fetch(32'h0, 0, "seq0"); consume(0, '0, 0, '0, 0);
        fetch(32'h4, 0, "seq1"); consume(0, '0, 0, '0, 0);
        fetch(32'h8, 0, "seq2"); consume(0, '0, 0, '0, 0);

        // Ack delayed by three cycles.
        fetch(32'hC, 3, "slow"); consume(0, '0, 0, '0, 0);

        // Stall at 0x10 for five cycles; a jump during stall is ignored.
        fetch(32'h10, 0, "stl");
        stall       = 1'b1;
        jump        = 1'b1;
        jump_target = 32'h0000_0999;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stl_valid", 32'(instr_valid), 32'd1);
            check("stl_pc",    pc,               32'h10);
            check("stl_req",   32'(imem_req),    32'd0);
        end
        clear_redirects();
        consume(1, 32'h41, 0, '0, 0);

        // Branch target aligned; then jump beats branch.
        fetch(32'h40, 0, "br");
        consume(1, 32'h99, 1, 32'h20, 0);

        // Exception in FETCH without ack, drained in FLUSH; a repeat
        // exception in FLUSH is ignored.
        wait_req("fx");
        check("fx_addr", imem_addr, 32'h20);
        exception = 1'b1;
        step();
        check("fx_flush_req",   32'(imem_req),    32'd0);
        check("fx_flush_valid", 32'(instr_valid), 32'd0);
        check("fx_epc",         epc,              32'h20);
        step();
        exception  = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_ack   = 1'b0;
        imem_rdata = '0;
        check("fx_drop_valid", 32'(instr_valid), 32'd0);
        check("fx_epc_kept",   epc,              32'h20);
        fetch(EXC_VEC, 1, "fx_vec");
        // eret beats branch.
        consume(1, 32'h99, 0, '0, 1);
        fetch(32'h20, 0, "eret"); consume(0, '0, 0, '0, 0);

        // Exception while stalled in VALID, with eret: exception wins.
        fetch(32'h24, 0, "vx");
        stall     = 1'b1;
        exception = 1'b1;
        eret      = 1'b1;
        step();
        clear_redirects();
        stall = 1'b0;
        check("vx_valid", 32'(instr_valid), 32'd0);
        check("vx_epc",   epc,              32'h24);
        check("vx_addr",  imem_addr,        EXC_VEC);

        // Exception in FETCH with ack in the same cycle: data discarded.
        wait_req("fa");
        exception  = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        step();
        clear_redirects();
        imem_ack   = 1'b0;
        imem_rdata = '0;
        check("fa_valid", 32'(instr_valid), 32'd0);
        check("fa_req",   32'(imem_req),    32'd1);
        check("fa_addr",  imem_addr,        EXC_VEC);
        check("fa_epc",   epc,              EXC_VEC);
        fetch(EXC_VEC, 0, "fa_vec");

        // Wrap-around of the sequential increment.
        consume(0, '0, 1, 32'hFFFF_FFFF, 0);
        fetch(32'hFFFF_FFFC, 0, "wrap");
        check("wrap_plus4", pc_plus4, 32'h0);
        consume(0, '0, 0, '0, 0);
        fetch(32'h0, 0, "wrap0"); consume(0, '0, 0, '0, 0);

        // Reset mid-FETCH, then a late ack while in IDLE.
        wait_req("rf");
        check("rf_addr", imem_addr, 32'h4);
        step();
        rst = 1'b1;
        step();
        rst        = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hFACE_FACE;
        check("rf_idle_req",   32'(imem_req),    32'd0);
        check("rf_idle_valid", 32'(instr_valid), 32'd0);
        check("rf_idle_epc",   epc,              32'd0);
        check("rf_idle_instr", instr,            32'd0);
        step();
        imem_ack   = 1'b0;
        imem_rdata = '0;
        check("rf_late_valid", 32'(instr_valid), 32'd0);
        check("rf_late_req",   32'(imem_req),    32'd1);
        fetch(RST_VEC, 0, "rf_vec");

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_pc_sequencer
